// File: rtl/compressed_weight_decoder.sv
// Stores per-row compressed index/value tables and streams one row back as dense per-column weight words.
// Latency: first w_valid 3 cycles after rd_start; 3 cycles per presented column, 2 per skipped sentinel column.
// Backpressure: w_valid/w_col/w_data/w_is_zero hold until w_ready; writes arriving while busy are dropped (wr_drop).
module compressed_weight_decoder #(
    parameter int           WORD_SIZE    = 64,
    parameter int           NUM_ROWS     = 64,
    parameter int           SRAM_DEPTH   = 64,
    parameter logic [6:0]   IDX_SENTINEL = 7'h7F
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_compressed,
    input  logic [5:0]            wr_comp_row,
    input  logic [5:0]            wr_comp_idx,
    input  logic [6:0]            wr_comp_ptr,
    input  logic [WORD_SIZE-1:0]  wr_comp_val,
    output logic                  wr_drop,
    input  logic                  rd_start,
    input  logic [5:0]            rd_row,
    input  logic                  rd_skip_zero,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [5:0]            w_col,
    output logic [WORD_SIZE-1:0]  w_data,
    output logic                  w_is_zero,
    output logic                  busy,
    output logic                  rd_done,
    output logic [6:0]            nz_count
);

    localparam int          TAB_ENTRIES = NUM_ROWS * SRAM_DEPTH;
    localparam logic [6:0]  DEPTH7      = 7'(SRAM_DEPTH);
    localparam logic [5:0]  COL_LAST    = 6'(SRAM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        IDX_RD,
        VAL_RD,
        PRESENT,
        DONE
    } state_t;

    state_t state, next_state;

    // Tables are plain storage: never reset, undefined until written.
    logic [6:0]           idx_tab [TAB_ENTRIES];
    logic [WORD_SIZE-1:0] val_tab [TAB_ENTRIES];

    logic [5:0] row_q;
    logic [5:0] col_q;
    logic       skip_q;
    logic [6:0] ptr_q;
    logic [6:0] nz_q;

    logic wr_ok;
    logic last_col;
    logic ptr_is_sent;

    // Busy covers the whole stream including the DONE cycle, so the table cannot change under a read.
    assign busy        = (state != IDLE);
    assign w_valid     = (state == PRESENT);
    assign rd_done     = (state == DONE);
    assign w_col       = col_q;
    assign last_col    = (col_q == COL_LAST);
    assign ptr_is_sent = (ptr_q == IDX_SENTINEL);
    assign wr_ok       = wr_compressed && !busy &&
                         ((wr_comp_ptr == IDX_SENTINEL) || (wr_comp_ptr < DEPTH7));

    // Table writes; a sentinel entry only touches the index table.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            idx_tab[{wr_comp_row, wr_comp_idx}] <= wr_comp_ptr;
            if (wr_comp_ptr != IDX_SENTINEL)
                val_tab[{wr_comp_row, wr_comp_ptr[5:0]}] <= wr_comp_val;
        end
    end

    // One-cycle drop pulse for writes rejected because of a busy stream or an out-of-range slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_drop <= 1'b0;
        else       wr_drop <= wr_compressed && !wr_ok;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (rd_start) next_state = IDX_RD;
            IDX_RD:  next_state = VAL_RD;
            VAL_RD: begin
                if (ptr_is_sent && skip_q) next_state = last_col ? DONE : IDX_RD;
                else                       next_state = PRESENT;
            end
            PRESENT: if (w_ready) next_state = last_col ? DONE : IDX_RD;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stream datapath: table lookups, column walk, output word and non-zero counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q     <= '0;
            col_q     <= '0;
            skip_q    <= 1'b0;
            ptr_q     <= '0;
            nz_q      <= '0;
            w_data    <= '0;
            w_is_zero <= 1'b0;
            nz_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        row_q  <= rd_row;
                        skip_q <= rd_skip_zero;
                        col_q  <= '0;
                        nz_q   <= '0;
                    end
                end
                IDX_RD: ptr_q <= idx_tab[{row_q, col_q}];
                VAL_RD: begin
                    if (ptr_is_sent) begin
                        w_data    <= '0;
                        w_is_zero <= 1'b1;
                        if (skip_q && !last_col) col_q <= col_q + 6'd1;
                    end else begin
                        w_data    <= val_tab[{row_q, ptr_q[5:0]}];
                        w_is_zero <= 1'b0;
                        nz_q      <= nz_q + 7'd1;
                    end
                end
                PRESENT: if (w_ready && !last_col) col_q <= col_q + 6'd1;
                DONE:    nz_count <= nz_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compressed_weight_decoder.sv
// Randomized self-checking bench for compressed_weight_decoder against a table/queue reference model.
// Latency: checks first-word and rd_done cycle counts on free-flowing streams.
// Backpressure: exercises stalls, random w_ready, writes and rd_start while busy, and async reset mid-stream.
module tb_compressed_weight_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_compressed;
    logic [5:0]  wr_comp_row;
    logic [5:0]  wr_comp_idx;
    logic [6:0]  wr_comp_ptr;
    logic [63:0] wr_comp_val;
    logic        wr_drop;
    logic        rd_start;
    logic [5:0]  rd_row;
    logic        rd_skip_zero;
    logic        w_valid;
    logic        w_ready;
    logic [5:0]  w_col;
    logic [63:0] w_data;
    logic        w_is_zero;
    logic        busy;
    logic        rd_done;
    logic [6:0]  nz_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference tables: what the host has successfully written.
    logic [6:0]  m_idx [64][64];
    logic [63:0] m_val [64][64];

    compressed_weight_decoder dut (
        .clk(clk), .reset(reset),
        .wr_compressed(wr_compressed), .wr_comp_row(wr_comp_row), .wr_comp_idx(wr_comp_idx),
        .wr_comp_ptr(wr_comp_ptr), .wr_comp_val(wr_comp_val), .wr_drop(wr_drop),
        .rd_start(rd_start), .rd_row(rd_row), .rd_skip_zero(rd_skip_zero),
        .w_valid(w_valid), .w_ready(w_ready), .w_col(w_col), .w_data(w_data),
        .w_is_zero(w_is_zero), .busy(busy), .rd_done(rd_done), .nz_count(nz_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at edge+1; returns at edge+1 after the write has been sampled.
    task automatic do_write(input logic [5:0] row, input logic [5:0] idx,
                            input logic [6:0] ptr, input logic [63:0] val);
        bit acc;
        wr_compressed = 1'b1;
        wr_comp_row   = row;
        wr_comp_idx   = idx;
        wr_comp_ptr   = ptr;
        wr_comp_val   = val;
        @(posedge clk); #1;
        wr_compressed = 1'b0;
        acc = (ptr == 7'h7F) || (ptr < 7'd64);
        check_eq("wr_drop", {63'd0, wr_drop}, {63'd0, !acc});
        if (acc) begin
            m_idx[row][idx] = ptr;
            if (ptr != 7'h7F) m_val[row][ptr[5:0]] = val;
        end
    endtask

    // mode 0: ready=1; 1: random ready; 2: 10-cycle stall on column 3;
    // 3: ready=1 plus a dropped write and an ignored rd_start while busy.
    task automatic run_stream(input logic [5:0] row, input logic skip, input int mode);
        logic [5:0]  q_col [$];
        logic [63:0] q_dat [$];
        logic        q_z   [$];
        int exp_nz = 0, exp_done = 1, exp_first = -1;
        int cyc = 0, first = -1, done_cyc = -1, stall = 0;
        bit done = 0;
        logic r;
        for (int c = 0; c < 64; c++) begin
            logic [6:0] p;
            bit sent;
            p = m_idx[row][c];
            sent = (p == 7'h7F);
            if (!sent) exp_nz++;
            if (sent && skip) begin
                exp_done += 2;
            end else begin
                if (exp_first < 0) exp_first = exp_done + 2;
                exp_done += 3;
                q_col.push_back(6'(c));
                q_dat.push_back(sent ? 64'd0 : m_val[row][p[5:0]]);
                q_z.push_back(sent);
            end
        end
        rd_row       = row;
        rd_skip_zero = skip;
        rd_start     = 1'b1;
        while (!done && cyc < 3000) begin
            if (cyc == 1) rd_start = 1'b0;
            if (mode == 3) begin
                if (cyc == 10) begin
                    wr_compressed = 1'b1; wr_comp_row = row; wr_comp_idx = 6'd0;
                    wr_comp_ptr = 7'd0; wr_comp_val = 64'hDEAD_BEEF_0000_0001;
                end
                if (cyc == 11) begin
                    wr_compressed = 1'b0;
                    check_eq("busy_wr_drop", {63'd0, wr_drop}, 64'd1);
                end
                if (cyc == 20) begin rd_start = 1'b1; rd_row = row + 6'd7; end
                if (cyc == 21) rd_start = 1'b0;
            end
            r = 1'b1;
            if (mode == 1) r = 1'($urandom_range(0, 1));
            if (mode == 2 && w_valid && w_col == 6'd3 && stall < 10) begin
                r = 1'b0;
                stall++;
                check_eq("stall_col", {58'd0, w_col}, 64'd3);
                check_eq("stall_data", w_data, q_dat.size() > 0 ? q_dat[0] : 64'hX);
            end
            w_ready = r;
            if (w_valid && first < 0) first = cyc;
            if (w_valid && r) begin
                if (q_col.size() == 0) begin
                    check_eq("extra_word", 64'd1, 64'd0);
                end else begin
                    check_eq("w_col", {58'd0, w_col}, {58'd0, q_col.pop_front()});
                    check_eq("w_data", w_data, q_dat.pop_front());
                    check_eq("w_is_zero", {63'd0, w_is_zero}, {63'd0, q_z.pop_front()});
                end
            end
            if (rd_done) begin
                done = 1;
                done_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq("rd_done_seen", {63'd0, done}, 64'd1);
        check_eq("words_left", 64'(q_col.size()), 64'd0);
        if (mode == 2) check_eq("stall_cycles", 64'(stall), 64'd10);
        if (mode == 0 || mode == 3) begin
            check_eq("first_valid_cyc", 64'(first), 64'(exp_first));
            check_eq("rd_done_cyc", 64'(done_cyc), 64'(exp_done));
        end
        @(posedge clk); #1;
        check_eq("nz_count", {57'd0, nz_count}, 64'(exp_nz));
        check_eq("busy_after", {63'd0, busy}, 64'd0);
        check_eq("rd_done_single", {63'd0, rd_done}, 64'd0);
        if (mode == 3) begin
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                check_eq("no_second_done", {63'd0, rd_done}, 64'd0);
            end
        end
    endtask

    initial begin
        int found;
        reset = 1'b1; wr_compressed = 1'b0; wr_comp_row = '0; wr_comp_idx = '0;
        wr_comp_ptr = '0; wr_comp_val = '0; rd_start = 1'b0; rd_row = '0;
        rd_skip_zero = 1'b0; w_ready = 1'b1;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                m_idx[r][c] = 7'h7F;
                m_val[r][c] = '0;
            end
        #12;
        check_eq("rst_w_valid", {63'd0, w_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_nz_count", {57'd0, nz_count}, 64'd0);
        check_eq("rst_w_data", w_data, 64'd0);
        check_eq("rst_outs", {58'd0, w_col, w_is_zero, rd_done, wr_drop}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Dense row 0.
        for (int i = 0; i < 64; i++) do_write(6'd0, 6'(i), 7'(i), 64'h1000 + 64'(i));
        run_stream(6'd0, 1'b0, 0);

        // Row 5: even columns populated, odd columns sentinel.
        for (int i = 0; i < 64; i++)
            if (i % 2 == 0) do_write(6'd5, 6'(i), 7'(i / 2), 64'(i));
            else            do_write(6'd5, 6'(i), 7'h7F, 64'hFFFF);
        run_stream(6'd5, 1'b0, 0);
        run_stream(6'd5, 1'b1, 0);

        // Backpressure on column 3.
        run_stream(6'd0, 1'b0, 2);

        // Dropped write and ignored rd_start while busy, then restream shows old data.
        run_stream(6'd0, 1'b0, 3);
        run_stream(6'd0, 1'b0, 0);

        // Out-of-range slot is dropped and the table stays unchanged.
        do_write(6'd0, 6'd1, 7'h40, 64'hBAD0);
        run_stream(6'd0, 1'b0, 0);

        // Async reset at column 20.
        rd_row = 6'd0; rd_skip_zero = 1'b0; w_ready = 1'b1; rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        found = 0;
        for (int n = 0; n < 500 && !found; n++) begin
            if (w_valid && w_col == 6'd20) found = 1;
            else begin @(posedge clk); #1; end
        end
        check_eq("reach_col20", 64'(found), 64'd1);
        #3 reset = 1'b1;
        #1;
        check_eq("arst_w_valid", {63'd0, w_valid}, 64'd0);
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_w_data", w_data, 64'd0);
        check_eq("arst_nz_count", {57'd0, nz_count}, 64'd0);
        check_eq("arst_outs", {58'd0, w_col, w_is_zero, rd_done, wr_drop}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_stream(6'd0, 1'b0, 0);

        // All-sentinel row with skipping.
        for (int i = 0; i < 64; i++) do_write(6'd9, 6'(i), 7'h7F, 64'(i));
        run_stream(6'd9, 1'b1, 0);

        // Random rows with random ready and occasional bad-slot writes.
        for (int t = 0; t < 4; t++) begin
            logic [5:0] row;
            row = 6'(12 + t);
            for (int i = 0; i < 64; i++) begin
                logic [6:0] p;
                p = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 63));
                do_write(row, 6'(i), p, {$urandom, $urandom});
            end
            for (int k = 0; k < 4; k++)
                do_write(row, 6'($urandom_range(0, 63)), 7'($urandom_range(64, 126)), {$urandom, $urandom});
            run_stream(row, 1'($urandom_range(0, 1)), 1);
            run_stream(row, 1'b1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
